// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the sample-RAM port arbiter.
package ram_arb_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_RD_LAT  = 2;
  localparam int ID_W        = 2;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rd_tag_t;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with burst lock in front of the single-port sample RAM;
// registers the RAM command and routes read returns back to the issuing requester.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_LAT  = DEF_RD_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata
);

  localparam int IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_v;

  assign addr_v  = addr;
  assign wdata_v = wdata;

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [ID_W-1:0]   cmd_id_q, cmd_id_d;
  rd_tag_t [RD_LAT:1] tag_q, tag_d;
  rd_tag_t           cmd_tag;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               acc;
  logic [IDX_W-1:0]   win;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Arbitration FSM: grant, accepted-beat detection and lock ownership.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    gnt      = '0;
    acc      = 1'b0;
    win      = pick_idx;
    case (state_q)
      ARB: begin
        gnt = pick_gnt;
        acc = pick_any;
        if (acc) begin
          rr_ptr_d = (win == IDX_W'(NUM_REQ-1)) ? '0 : win + IDX_W'(1);
          if (lock[win]) begin
            owner_d = win;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        win = owner_q;
        if (req[owner_q]) begin
          gnt[owner_q] = 1'b1;
          acc          = 1'b1;
          if (!lock[owner_q]) state_d = ARB;
        end else begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Command register holds its fields when idle; only ram_en drops.
  always_comb begin
    ram_en_d    = acc;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cmd_id_d    = cmd_id_q;
    if (acc) begin
      ram_we_d    = we[win];
      ram_addr_d  = addr_v[win];
      ram_wdata_d = wdata_v[win];
      cmd_id_d    = ID_W'(win);
    end
    cmd_tag.valid = ram_en_q && !ram_we_q;
    cmd_tag.id    = cmd_id_q;
    tag_d         = tag_q;
    tag_d[1]      = cmd_tag;
    for (int k = 2; k <= RD_LAT; k++) tag_d[k] = tag_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cmd_id_q    <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cmd_id_q    <= cmd_id_d;
      tag_q       <= tag_d;
    end
  end

  // The oldest tag lines up with the cycle the RAM presents read data.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rvalid
    assign rvalid[i] = tag_q[RD_LAT].valid && (tag_q[RD_LAT].id == ID_W'(i));
  end

  assign rdata     = ram_rdata;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule
